// File: rtl/master_alu.sv
// Registered 32-bit ARM-style data-processing ALU with condition evaluation against NZCV flags.
// Optional immediate rotate-right: define MASTER_ALU_IMM_ROR_EN.
module master_alu #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 In_Valid,
  input  logic [WIDTH-1:0]     Reg1,
  input  logic [WIDTH-1:0]     Reg2,
  input  logic [IMM_WIDTH-1:0] IV,
  input  logic                 IV_Sel,
  input  logic [4:0]           IV_ShftRor,
  input  logic [3:0]           OpCode,
  input  logic [3:0]           Cond,
  input  logic                 S,
  output logic [WIDTH-1:0]     Result,
  output logic                 Wr_En,
  output logic                 Out_Valid,
  output logic [3:0]           Flag
);

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } op_e;

  logic             flag_n, flag_z, flag_c, flag_v;
  logic [WIDTH-1:0] imm_ext, imm_val, op2;
  logic             imm_carry_en;
  logic             cond_pass;
  logic [WIDTH-1:0] add_a, add_b;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             is_arith, is_test, exec;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       new_flags;

  assign {flag_n, flag_z, flag_c, flag_v} = Flag;
  assign imm_ext = {{(WIDTH-IMM_WIDTH){1'b0}}, IV};

`ifdef MASTER_ALU_IMM_ROR_EN
  // Rotating a doubled copy right leaves the rotated value in the low half.
  logic [2*WIDTH-1:0] imm_dbl;
  assign imm_dbl      = {imm_ext, imm_ext} >> IV_ShftRor;
  assign imm_val      = imm_dbl[WIDTH-1:0];
  assign imm_carry_en = IV_Sel & S & (IV_ShftRor != 5'd0);
`else
  logic unused_shift;
  assign unused_shift = ^IV_ShftRor;
  assign imm_val      = imm_ext;
  assign imm_carry_en = 1'b0;
`endif

  assign op2 = IV_Sel ? imm_val : Reg2;

  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c & !flag_z;
      4'h9: cond_pass = !flag_c | flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z & (flag_n == flag_v);
      4'hD: cond_pass = flag_z | (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Subtracts are folded into one adder as a + ~b + carry-in, so C=1 means no borrow.
  always_comb begin
    add_a    = Reg1;
    add_b    = op2;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (op_e'(OpCode))
      OP_SUB, OP_CMP: begin add_b = ~op2; add_cin = 1'b1; end
      OP_RSB:         begin add_a = op2; add_b = ~Reg1; add_cin = 1'b1; end
      OP_ADD, OP_CMN: add_cin = 1'b0;
      OP_ADC:         add_cin = flag_c;
      OP_SBC:         begin add_b = ~op2; add_cin = flag_c; end
      OP_RSC:         begin add_a = op2; add_b = ~Reg1; add_cin = flag_c; end
      default:        is_arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  always_comb begin
    alu_out = sum[WIDTH-1:0];
    case (op_e'(OpCode))
      OP_AND, OP_TST: alu_out = Reg1 & op2;
      OP_EOR, OP_TEQ: alu_out = Reg1 ^ op2;
      OP_ORR:         alu_out = Reg1 | op2;
      OP_MOV:         alu_out = op2;
      OP_BIC:         alu_out = Reg1 & ~op2;
      OP_MVN:         alu_out = ~op2;
      default:        alu_out = sum[WIDTH-1:0];
    endcase
  end

  always_comb begin
    new_flags[3] = alu_out[WIDTH-1];
    new_flags[2] = (alu_out == '0);
    if (is_arith) begin
      new_flags[1] = sum[WIDTH];
      new_flags[0] = (add_a[WIDTH-1] == add_b[WIDTH-1]) & (sum[WIDTH-1] != add_a[WIDTH-1]);
    end else begin
      new_flags[1] = imm_carry_en ? imm_val[WIDTH-1] : flag_c;
      new_flags[0] = flag_v;
    end
  end

  assign is_test = (OpCode[3:2] == 2'b10);
  assign exec    = In_Valid & cond_pass;

  // Compare/test opcodes only touch flags; everything else writes back and sets flags on S.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Result    <= '0;
      Wr_En     <= 1'b0;
      Out_Valid <= 1'b0;
      Flag      <= 4'b0000;
    end else begin
      Out_Valid <= In_Valid;
      Wr_En     <= exec & !is_test;
      if (exec & !is_test)
        Result <= alu_out;
      if (exec & (is_test | S))
        Flag <= new_flags;
    end
  end

endmodule

// File: tb/tb_master_alu.sv
// Self-checking bench for master_alu: directed scenarios then random operations
// compared against an arithmetic reference model.
module tb_master_alu;

`ifdef MASTER_ALU_IMM_ROR_EN
  localparam bit RorEn = 1'b1;
`else
  localparam bit RorEn = 1'b0;
`endif

  logic        Clk, Rst, In_Valid, IV_Sel, S;
  logic [31:0] Reg1, Reg2, Result;
  logic [15:0] IV;
  logic [4:0]  IV_ShftRor;
  logic [3:0]  OpCode, Cond, Flag;
  logic        Wr_En, Out_Valid;

  int tot = 0;
  int bad = 0;

  logic [31:0] m_res;
  logic        m_wr, m_ov;
  logic [3:0]  m_flag;

  master_alu dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .Reg1(Reg1), .Reg2(Reg2),
    .IV(IV), .IV_Sel(IV_Sel), .IV_ShftRor(IV_ShftRor), .OpCode(OpCode),
    .Cond(Cond), .S(S), .Result(Result), .Wr_En(Wr_En),
    .Out_Valid(Out_Valid), .Flag(Flag)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] immOf(input logic [15:0] iv, input logic [4:0] sh);
    logic [31:0] x;
    x = {16'h0000, iv};
    if (RorEn)
      for (int i = 0; i < int'(sh); i++) x = {x[0], x[31:1]};
    return x;
  endfunction

  // Reference model: exact integer arithmetic on 64-bit values, flags read off the true result.
  task automatic modelStep(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [15:0] iv, input logic sel, input logic [4:0] sh,
                           input logic [3:0] op, input logic [3:0] cond, input logic s);
    bit n, z, c, ov, pass, arith, upd;
    longint ua, ub, sa, sb, u, sv, bw;
    logic [31:0] b, res;
    {n, z, c, ov} = m_flag;
    m_ov = v;
    case (cond)
      0: pass = z;          1: pass = !z;
      2: pass = c;          3: pass = !c;
      4: pass = n;          5: pass = !n;
      6: pass = ov;         7: pass = !ov;
      8: pass = c && !z;    9: pass = !c || z;
      10: pass = (n == ov); 11: pass = (n != ov);
      12: pass = !z && (n == ov);
      13: pass = z || (n != ov);
      14: pass = 1;
      default: pass = 0;
    endcase
    if (!v || !pass) begin
      m_wr = 0;
      return;
    end
    b  = sel ? immOf(iv, sh) : r2;
    ua = r1;  ub = b;
    sa = $signed(r1);  sb = $signed(b);
    bw = c ? 0 : 1;
    arith = 1;
    u = 0; sv = 0; res = 0;
    case (op)
      4'h4, 4'hB: begin u = ua + ub;     sv = sa + sb;     c = (u > 64'hFFFFFFFF); end
      4'h5:       begin u = ua + ub + (1 - bw); sv = sa + sb + (1 - bw); c = (u > 64'hFFFFFFFF); end
      4'h2, 4'hA: begin u = ua - ub;     sv = sa - sb;     c = (ua >= ub); end
      4'h3:       begin u = ub - ua;     sv = sb - sa;     c = (ub >= ua); end
      4'h6:       begin u = ua - ub - bw; sv = sa - sb - bw; c = (ua >= ub + bw); end
      4'h7:       begin u = ub - ua - bw; sv = sb - sa - bw; c = (ub >= ua + bw); end
      default:    arith = 0;
    endcase
    if (arith) begin
      res = u[31:0];
      ov  = (sv != longint'($signed(res)));
    end else begin
      case (op)
        4'h0, 4'h8: res = r1 & b;
        4'h1, 4'h9: res = r1 ^ b;
        4'hC:       res = r1 | b;
        4'hD:       res = b;
        4'hE:       res = r1 & ~b;
        default:    res = ~b;
      endcase
      if (RorEn && sel && s && sh != 0) c = b[31];
    end
    n = res[31];
    z = (res == 0);
    if (op >= 4'h8 && op <= 4'hB) begin
      m_wr = 0;
      upd  = 1;
    end else begin
      m_wr  = 1;
      m_res = res;
      upd   = s;
    end
    if (upd) m_flag = {n, z, c, ov};
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                               input logic [15:0] iv, input logic sel, input logic [4:0] sh,
                               input logic [3:0] op, input logic [3:0] cond, input logic s);
    In_Valid = v;  Reg1 = r1;  Reg2 = r2;  IV = iv;  IV_Sel = sel;
    IV_ShftRor = sh;  OpCode = op;  Cond = cond;  S = s;
    modelStep(v, r1, r2, iv, sel, sh, op, cond, s);
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".result"}, Result, m_res);
    checkOutput({tag, ".wr_en"}, 32'(Wr_En), 32'(m_wr));
    checkOutput({tag, ".out_valid"}, 32'(Out_Valid), 32'(m_ov));
    checkOutput({tag, ".flag"}, 32'(Flag), 32'(m_flag));
  endtask

  function automatic logic [31:0] pickVal();
    logic [31:0] edges [5] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h1};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    Rst = 1'b1;  In_Valid = 0;  Reg1 = 0;  Reg2 = 0;  IV = 0;  IV_Sel = 0;
    IV_ShftRor = 0;  OpCode = 0;  Cond = 0;  S = 0;
    m_res = 0;  m_wr = 0;  m_ov = 0;  m_flag = 0;
    repeat (2) @(posedge Clk);
    #1;
    checkAll("reset");
    Rst = 1'b0;

    $display("[TB] directed scenarios");
    applyStimulus(1, 32'h7FFFFFFF, 32'h1, 16'h0, 0, 0, 4'h4, 4'hE, 1);
    checkOutput("add_ovf.result", Result, 32'h80000000);
    checkOutput("add_ovf.flag", 32'(Flag), 32'h9);
    checkOutput("add_ovf.wr_en", 32'(Wr_En), 32'h1);
    checkAll("add_ovf");

    applyStimulus(1, 32'h5, 32'h0, 16'h5, 1, 0, 4'hA, 4'hE, 0);
    checkOutput("cmp_eq.flag", 32'(Flag), 32'h6);
    checkOutput("cmp_eq.wr_en", 32'(Wr_En), 32'h0);
    checkAll("cmp_eq");

    applyStimulus(1, 32'h0, 32'h0, 16'h00AA, 1, 0, 4'hD, 4'h0, 0);
    checkOutput("mov_eq.result", Result, 32'h000000AA);
    checkOutput("mov_eq.wr_en", 32'(Wr_En), 32'h1);
    checkAll("mov_eq");

    applyStimulus(1, 32'h9, 32'h3, 16'h0, 0, 0, 4'h2, 4'h1, 1);
    checkOutput("ne_skip.wr_en", 32'(Wr_En), 32'h0);
    checkOutput("ne_skip.result", Result, 32'h000000AA);
    checkOutput("ne_skip.flag", 32'(Flag), 32'h6);

    applyStimulus(1, 32'hFFFFFFFF, 32'h0, 16'h0, 0, 0, 4'h5, 4'hE, 1);
    checkOutput("adc_wrap.result", Result, 32'h0);
    checkOutput("adc_wrap.flag", 32'(Flag), 32'h6);
    checkAll("adc_wrap");

    applyStimulus(1, 32'h0, 32'h0, 16'h0001, 1, 5'd1, 4'hD, 4'hE, 1);
    if (RorEn) begin
      checkOutput("mov_ror.result", Result, 32'h80000000);
      checkOutput("mov_ror.flag", 32'(Flag), 32'hA);
    end else begin
      checkOutput("mov_ror.result", Result, 32'h00000001);
      checkOutput("mov_ror.flag", 32'(Flag), 32'h2);
    end
    checkAll("mov_ror");

    // Reset lands while an ADD is pending and is held across its edge.
    In_Valid = 1;  Reg1 = 32'h10;  Reg2 = 32'h20;  IV_Sel = 0;
    OpCode = 4'h4;  Cond = 4'hE;  S = 1;
    #2;
    Rst = 1'b1;
    #1;
    m_res = 0;  m_wr = 0;  m_ov = 0;  m_flag = 0;
    checkAll("async_rst");
    @(posedge Clk);
    #1;
    checkAll("rst_held");
    Rst = 1'b0;

    $display("[TB] random operations");
    for (int i = 0; i < 400; i++) begin
      logic [3:0] cond;
      cond = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 7) != 0), pickVal(), pickVal(), 16'($urandom),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    4'($urandom_range(0, 15)), cond, 1'($urandom_range(0, 1)));
      checkAll($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
